mic_adc_reader: RTL

MIC_ADC_READER -- requirements
Module: mic_adc_reader

---
 rtl/mic_adc_reader.sv | 87 ++++++++
 1 files changed

// File: rtl/mic_adc_reader.sv
// mic_adc_reader: periodic 10-bit serial ADC reader producing one microphone sample per frame
module mic_adc_reader #(
  parameter int CLK_DIV = 12,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic       clk_48,
  input  logic       rst,
  input  logic       en,
  input  logic       adc_miso,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic [9:0] mic_sample,
  output logic       sample_valid,
  output logic       overrun
);
  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE} state_t;
  localparam logic [15:0] PER_LAST = 16'(SAMPLE_PERIOD - 1);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  state_t state;
  logic [15:0] per_cnt;
  logic [7:0] div_cnt;
  logic [4:0] edge_cnt;
  logic [9:0] shreg;
  logic [1:0] sync;
  logic tick;
  logic div_done;
  assign tick = per_cnt == 16'd0;
  assign div_done = div_cnt == DIV_LAST;
  // free-running frame period counter, tick at zero
  always_ff @(posedge clk_48) begin
    if (rst) per_cnt <= '0;
    else per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + 16'd1;
  end
  // two-flop synchronizer for the asynchronous ADC data line
  always_ff @(posedge clk_48) begin
    if (rst) sync <= '0;
    else sync <= {sync[0], adc_miso};
  end
  // frame sequencer: chip select, serial clock generation and bit capture
  always_ff @(posedge clk_48) begin
    if (rst) begin
      state <= IDLE;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b0;
      mic_sample <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
      div_cnt <= '0;
      edge_cnt <= '0;
      shreg <= '0;
    end else begin
      sample_valid <= 1'b0;
      overrun <= tick && state != IDLE;
      div_cnt <= (state == IDLE || state == DONE || div_done) ? '0 : div_cnt + 8'd1;
      case (state)
        IDLE: if (tick && en) begin
          state <= CS_SETUP;
          adc_cs_n <= 1'b0;
          edge_cnt <= '0;
          shreg <= '0;
        end
        CS_SETUP: if (div_done) begin
          state <= SHIFT;
          adc_sclk <= 1'b1;
          edge_cnt <= 5'd1;
        end
        SHIFT: if (div_done) begin
          if (adc_sclk) adc_sclk <= 1'b0;
          else if (edge_cnt == 5'd16) begin
            state <= CS_HOLD;
            adc_cs_n <= 1'b1;
          end else begin
            adc_sclk <= 1'b1;
            edge_cnt <= edge_cnt + 5'd1;
            if (edge_cnt >= 5'd3 && edge_cnt <= 5'd12) shreg <= {shreg[8:0], sync[1]};
          end
        end
        CS_HOLD: if (div_done) begin
          state <= DONE;
          mic_sample <= shreg;
          sample_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
